// File: rtl/mux_scan_pkg.sv
// Shared types for the scan multiplexer: FSM state encoding and mode values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/mux_scan_sel_nto1.sv
// Combinational N:1 indexed select of a WIDTH-bit slice from a flat bus.
// Latency: 0 cycles; an index >= CH yields all zeros.
// Backpressure: none (pure logic).
module mux_nto1 #(
    parameter int WIDTH = 1,
    parameter int CH    = 8,
    parameter int SELW  = $clog2(CH)
) (
    input  logic [CH*WIDTH-1:0] bus,
    input  logic [SELW-1:0]     idx,
    output logic [WIDTH-1:0]    dat
);

    // Priority-free compare against every channel index; unmatched indices give zero.
    always_comb begin
        dat = '0;
        for (int k = 0; k < CH; k++) begin
            if (idx == SELW'(k)) begin
                dat = bus[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// N:1 channel mux with registered output: one manual beat, or an auto sweep of a snapshot (MUX_SCAN_CONT_EN adds continuous sweeps).
// Latency: req at edge k gives out_valid at edge k+1; one beat per cycle while out_ready is high.
// Backpressure: out_data/out_ch hold while out_valid && !out_ready; req is ignored unless IDLE.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CH    = 8,
    parameter int SELW  = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]     sel,
    input  logic                mode,
    input  logic                req,
    output logic [WIDTH-1:0]    out_data,
    output logic [SELW-1:0]     out_ch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef MUX_SCAN_CONT_EN
    ,
    input  logic                cont
`endif
);

    localparam logic [SELW:0]   CH_L = CH[SELW:0];
    localparam logic [SELW-1:0] LAST = SELW'(CH - 1);

    state_t                state_q, state_d;
    logic [CH*WIDTH-1:0]   snap_q, snap_d;
    logic [WIDTH-1:0]      data_d;
    logic [SELW-1:0]       ch_d;
    logic                  valid_d, done_d, err_d;
    logic [WIDTH-1:0]      man_dat, scan_dat;
    logic [SELW-1:0]       next_ch;
    logic                  hs, wrap;

    assign hs      = out_valid && out_ready;
    assign next_ch = out_ch + SELW'(1);
    assign busy    = (state_q != IDLE);

`ifdef MUX_SCAN_CONT_EN
    assign wrap = cont;
`else
    assign wrap = 1'b0;
`endif

    // Live bus select for manual beats.
    mux_nto1 #(.WIDTH(WIDTH), .CH(CH)) u_man_sel (
        .bus (in_data),
        .idx (sel),
        .dat (man_dat)
    );

    // Snapshot select for the beat following the current one in a sweep.
    mux_nto1 #(.WIDTH(WIDTH), .CH(CH)) u_scan_sel (
        .bus (snap_q),
        .idx (next_ch),
        .dat (scan_dat)
    );

    // Next-state and next-output logic; everything holds unless a transition fires.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        data_d  = out_data;
        ch_d    = out_ch;
        valid_d = out_valid;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (req) begin
                    if (mode == MODE_MANUAL) begin
                        if ({1'b0, sel} < CH_L) begin
                            data_d  = man_dat;
                            ch_d    = sel;
                            valid_d = 1'b1;
                            state_d = MAN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        snap_d  = in_data;
                        data_d  = in_data[0 +: WIDTH];
                        ch_d    = '0;
                        valid_d = 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            MAN: begin
                if (hs) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (hs) begin
                    if (out_ch != LAST) begin
                        ch_d   = next_ch;
                        data_d = scan_dat;
                    end else if (wrap) begin
                        // Back-to-back sweep: fresh snapshot, channel 0 without a bubble.
                        snap_d = in_data;
                        data_d = in_data[0 +: WIDTH];
                        ch_d   = '0;
                        done_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, snapshot and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            out_data  <= data_d;
            out_ch    <= ch_d;
            out_valid <= valid_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: manual, sweep, stall, async reset, out-of-range select, optional continuous sweep.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven by the bench to stall sweeps.
module tb_mux_scan_sel;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // CH=8, WIDTH=1 instance
    logic [7:0] in8 = '0;
    logic [2:0] sel8 = '0;
    logic       mode8 = 1'b0, req8 = 1'b0, rdy8 = 1'b1;
    logic [0:0] od8;
    logic [2:0] oc8;
    logic       ov8, busy8, done8, err8;

    // CH=6, WIDTH=1 instance
    logic [5:0] in6 = '0;
    logic [2:0] sel6 = '0;
    logic       req6 = 1'b0;
    logic [0:0] od6;
    logic [2:0] oc6;
    logic       ov6, busy6, done6, err6;

`ifdef MUX_SCAN_CONT_EN
    logic cont_off = 1'b0;
`endif

    mux_scan_sel #(.WIDTH(1), .CH(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(in8), .sel(sel8), .mode(mode8), .req(req8),
        .out_data(od8), .out_ch(oc8), .out_valid(ov8), .out_ready(rdy8),
        .busy(busy8), .done(done8), .err(err8)
`ifdef MUX_SCAN_CONT_EN
        , .cont(cont_off)
`endif
    );

    mux_scan_sel #(.WIDTH(1), .CH(6)) dut6 (
        .clk(clk), .rst(rst), .in_data(in6), .sel(sel6), .mode(1'b0), .req(req6),
        .out_data(od6), .out_ch(oc6), .out_valid(ov6), .out_ready(1'b1),
        .busy(busy6), .done(done6), .err(err6)
`ifdef MUX_SCAN_CONT_EN
        , .cont(cont_off)
`endif
    );

`ifdef MUX_SCAN_CONT_EN
    logic [15:0] in4 = '0;
    logic        req4 = 1'b0, cont4 = 1'b1;
    logic [3:0]  od4;
    logic [1:0]  oc4;
    logic        ov4, busy4, done4, err4;

    mux_scan_sel #(.WIDTH(4), .CH(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in4), .sel(2'd0), .mode(1'b1), .req(req4),
        .out_data(od4), .out_ch(oc4), .out_valid(ov4), .out_ready(1'b1),
        .busy(busy4), .done(done4), .err(err4), .cont(cont4)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int beats, cycles, stall;
        pat = 8'b10110101;

        // Reset state
        #3;
        chk("rst_valid", ov8, 0);
        chk("rst_data", od8, 0);
        chk("rst_ch", oc8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_err", err8, 0);
        step();
        rst = 1'b0;
        step();

        // Manual beats sel=0..7; next req issued in the done cycle
        in8 = pat;
        for (int s = 0; s < 8; s++) begin
            req8 = 1'b1; mode8 = 1'b0; sel8 = 3'(s);
            step();
            req8 = 1'b0;
            chk($sformatf("man_valid%0d", s), ov8, 1);
            chk($sformatf("man_data%0d", s), od8, 32'(pat[s]));
            chk($sformatf("man_ch%0d", s), oc8, s);
            chk($sformatf("man_busy%0d", s), busy8, 1);
            step();
            chk($sformatf("man_done%0d", s), done8, 1);
            chk($sformatf("man_vlow%0d", s), ov8, 0);
        end
        step();
        chk("man_done_clear", done8, 0);

        // Auto sweep; bus cleared after snapshot
        req8 = 1'b1; mode8 = 1'b1;
        step();
        req8 = 1'b0; in8 = 8'h00;
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("scan_valid%0d", b), ov8, 1);
            chk($sformatf("scan_ch%0d", b), oc8, b);
            chk($sformatf("scan_data%0d", b), od8, 32'(pat[b]));
            chk($sformatf("scan_busy%0d", b), busy8, 1);
            chk($sformatf("scan_nodone%0d", b), done8, 0);
            step();
        end
        chk("scan_end_valid", ov8, 0);
        chk("scan_end_done", done8, 1);
        chk("scan_end_busy", busy8, 0);
        step();
        chk("scan_done_clear", done8, 0);

        // Sweep with a 3-cycle stall on channel 3
        in8 = pat; req8 = 1'b1; mode8 = 1'b1;
        step();
        req8 = 1'b0;
        beats = 0; cycles = 0; stall = 0;
        while (ov8 && cycles < 40) begin
            if (oc8 == 3'd3 && stall < 3) begin
                rdy8 = 1'b0;
                stall++;
                chk("stall_data", od8, 0);
                chk("stall_ch", oc8, 3);
            end else begin
                rdy8 = 1'b1;
                chk("bp_ch", oc8, beats);
                chk("bp_data", od8, 32'(pat[beats[2:0]]));
                beats++;
            end
            step();
            cycles++;
        end
        rdy8 = 1'b1;
        chk("bp_beats", beats, 8);
        chk("bp_cycles", cycles, 11);
        chk("bp_done", done8, 1);
        step();

        // Asynchronous reset mid-sweep at channel 5
        req8 = 1'b1; mode8 = 1'b1;
        step();
        req8 = 1'b0;
        cycles = 0;
        while (oc8 != 3'd5 && cycles < 20) begin
            step();
            cycles++;
        end
        chk("pre_rst_ch", oc8, 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", ov8, 0);
        chk("arst_data", od8, 0);
        chk("arst_ch", oc8, 0);
        chk("arst_busy", busy8, 0);
        chk("arst_done", done8, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_done", done8, 0);
        req8 = 1'b1; mode8 = 1'b1;
        step();
        req8 = 1'b0;
        chk("restart_ch", oc8, 0);
        chk("restart_valid", ov8, 1);
        chk("restart_data", od8, 1);
        repeat (9) step();

        // CH=6: out-of-range manual select, then a legal one
        in6 = 6'b100000; sel6 = 3'd7; req6 = 1'b1;
        step();
        req6 = 1'b0;
        chk("oor_err", err6, 1);
        chk("oor_valid", ov6, 0);
        chk("oor_busy", busy6, 0);
        step();
        chk("oor_err_clear", err6, 0);
        chk("oor_valid2", ov6, 0);
        sel6 = 3'd5; req6 = 1'b1;
        step();
        req6 = 1'b0;
        chk("ch6_valid", ov6, 1);
        chk("ch6_ch", oc6, 5);
        chk("ch6_data", od6, 1);
        chk("ch6_err", err6, 0);
        step();
        chk("ch6_done", done6, 1);

`ifdef MUX_SCAN_CONT_EN
        begin
            logic [3:0] exp4 [8];
            exp4 = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
            in4 = 16'hDCBA; cont4 = 1'b1; req4 = 1'b1;
            step();
            req4 = 1'b0; in4 = 16'h4321;
            for (int b = 0; b < 8; b++) begin
                if (b >= 4) cont4 = 1'b0;
                chk($sformatf("cont_valid%0d", b), ov4, 1);
                chk($sformatf("cont_data%0d", b), od4, exp4[b]);
                chk($sformatf("cont_ch%0d", b), oc4, b % 4);
                chk($sformatf("cont_done%0d", b), done4, (b == 4) ? 1 : 0);
                step();
            end
            chk("cont_end_valid", ov4, 0);
            chk("cont_end_done", done4, 1);
            chk("cont_end_busy", busy4, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
